request_queue: RTL and testbench

- Bounded in-order memory-request queue between the trace parser and the DRAM scheduler.
- Accepts one parsed request per CPU_clock when the parser marks it ready; holds up to DEPTH entries.
- Presents the oldest entry (show-ahead) to the consumer and removes it on a pop request.
- Reports full/empty/occupancy status for back-pressure and scheduling.

---
 rtl/global_defs.sv | 21 ++
 rtl/request_queue.sv | 70 +++++++
 tb/tb_request_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/global_defs.sv
// global_defs: shared request-queue constants, opcode enum and the parser request record.
package global_defs;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 33;
    localparam int TIME_W = 64;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2
    } opcode_e;

    typedef struct packed {
        logic [TIME_W-1:0] CPU_clock_count;
        logic [1:0]        opcode;
        logic [ADDR_W-1:0] address;
        logic              op_ready_s;
    } parser_out_struct;
endpackage

// File: rtl/request_queue.sv
// request_queue: bounded in-order show-ahead queue between trace parser and DRAM scheduler.
module request_queue
    import global_defs::*;
(
    input  logic             CPU_clock,
    input  logic             rst_n,
    input  parser_out_struct fifo_input,
    input  logic             exit_flag,
    output parser_out_struct fifo_output,
    output logic             full,
    output logic             empty,
    output logic             insert_flag,
    output logic [CNT_W-1:0] count
);
    parser_out_struct mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic push, pop;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = count == CNT_W'(DEPTH);
    assign empty       = count == '0;
    assign pop         = exit_flag && !empty;
    assign push        = fifo_input.op_ready_s && (!full || pop);
    assign fifo_output = empty ? '0 : mem[head];

    always_ff @(posedge CPU_clock or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            insert_flag <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            insert_flag <= push;
            if (push) begin
                mem[tail]            <= fifo_input;
                mem[tail].op_ready_s <= 1'b1;
                tail                 <= inc_ptr(tail);
            end
            if (pop) head <= inc_ptr(head);
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

`ifdef QUEUE_DEBUG_EN
    function automatic string dump_q();
        string s;
        logic [PTR_W-1:0] p;
        s = "";
        p = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                s = {s, $sformatf(" [t=%0h op=%0h a=%0h]", mem[p].CPU_clock_count, mem[p].opcode, mem[p].address)};
                p = inc_ptr(p);
            end
        end
        return s;
    endfunction

    string ev;
    always @(posedge CPU_clock) begin
        ev = {push ? " PUSH" : "", pop ? " POP" : ""};
        $strobe("%0t count=%0d%s%s", $time, count, ev, dump_q());
    end
`endif
endmodule

// File: tb/tb_request_queue.sv
// tb_request_queue: directed self-checking bench for request_queue with a queue scoreboard.
module tb_request_queue;
    import global_defs::*;

    logic             CPU_clock = 1'b0;
    logic             rst_n;
    parser_out_struct fifo_input;
    logic             exit_flag;
    parser_out_struct fifo_output;
    logic             full, empty, insert_flag;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;
    parser_out_struct exp_q[$];
    parser_out_struct e;

    request_queue dut (
        .CPU_clock  (CPU_clock),
        .rst_n      (rst_n),
        .fifo_input (fifo_input),
        .exit_flag  (exit_flag),
        .fifo_output(fifo_output),
        .full       (full),
        .empty      (empty),
        .insert_flag(insert_flag),
        .count      (count)
    );

    always #5 CPU_clock = ~CPU_clock;

    function automatic parser_out_struct mk(input logic [63:0] t, input logic [1:0] op, input logic [32:0] a);
        parser_out_struct r;
        r.CPU_clock_count = t;
        r.opcode          = op;
        r.address         = a;
        r.op_ready_s      = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CPU_clock);
        #1;
    endtask

    // One cycle of stimulus; the scoreboard applies the same accept rules from the queue's outside view.
    task automatic cycle(input logic rdy, input parser_out_struct d, input logic ex);
        logic dp, dq;
        dq = ex && exp_q.size() > 0;
        dp = rdy && (exp_q.size() < DEPTH || dq);
        fifo_input = rdy ? d : '0;
        exit_flag  = ex;
        tick();
        fifo_input = '0;
        exit_flag  = 1'b0;
        if (dq) void'(exp_q.pop_front());
        if (dp) exp_q.push_back(d);
        chk("cyc_insert", 128'(insert_flag), 128'(dp));
        chk("cyc_count", 128'(count), 128'(exp_q.size()));
        chk("cyc_head", 128'(fifo_output), exp_q.size() > 0 ? 128'(exp_q[0]) : 128'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        fifo_input = '0;
        exit_flag  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_out", 128'(fifo_output), 128'(0));
        chk("rst_insert", 128'(insert_flag), 128'(0));

        e = mk(64'd10, 2'd1, 33'h1_2345_6780);
        cycle(1'b1, e, 1'b0);
        chk("single_empty", 128'(empty), 128'(0));
        chk("single_out", 128'(fifo_output), 128'(e));
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("single_drained", 128'(empty), 128'(1));

        for (int i = 0; i < 16; i++) cycle(1'b1, mk(64'(i), 2'(i % 3), 33'h100 + 33'(i)), 1'b0);
        chk("fill_full", 128'(full), 128'(1));
        chk("fill_count", 128'(count), 128'(16));
        cycle(1'b1, mk(64'd99, 2'd0, 33'h110), 1'b0);
        chk("overflow_count", 128'(count), 128'(16));
        chk("overflow_insert", 128'(insert_flag), 128'(0));

        for (int i = 0; i < 16; i++) begin
            chk("drain_addr", 128'(fifo_output.address), 128'(33'h100 + 33'(i)));
            cycle(1'b0, '0, 1'b1);
        end
        chk("drain_empty", 128'(empty), 128'(1));
        chk("drain_out", 128'(fifo_output), 128'(0));
        cycle(1'b0, '0, 1'b1);
        chk("underflow_count", 128'(count), 128'(0));

        for (int i = 0; i < 16; i++) cycle(1'b1, mk(64'(100 + i), 2'd2, 33'h100 + 33'(i)), 1'b0);
        cycle(1'b1, mk(64'd200, 2'd1, 33'h200), 1'b1);
        chk("pp_full_count", 128'(count), 128'(16));
        chk("pp_full_head", 128'(fifo_output.address), 128'(33'h101));
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
        chk("pp_empty_again", 128'(empty), 128'(1));
        e = mk(64'd300, 2'd0, 33'h1_FFFF_FFFF);
        cycle(1'b1, e, 1'b1);
        chk("pp_empty_count", 128'(count), 128'(1));
        chk("pp_empty_out", 128'(fifo_output), 128'(e));
        cycle(1'b0, '0, 1'b1);

        for (int i = 0; i < 40; i++)
            cycle(i % 3 != 2, mk(64'(1000 + i), 2'(i % 3), 33'h300 + 33'(i)), i % 2 == 1);
        while (exp_q.size() > 0) cycle(1'b0, '0, 1'b1);
        chk("wrap_empty", 128'(empty), 128'(1));

        for (int i = 0; i < 5; i++) cycle(1'b1, mk(64'(i), 2'd1, 33'h400 + 33'(i)), 1'b0);
        chk("pre_reset_count", 128'(count), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 128'(count), 128'(0));
        chk("async_rst_empty", 128'(empty), 128'(1));
        chk("async_rst_out", 128'(fifo_output), 128'(0));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1);
        chk("post_rst_count", 128'(count), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
